// File: rtl/ic_pkg.sv
// Shared definitions for the instruction cache: geometry, derived address
// widths, refill FSM encoding, the word-address field layout and the reset PC
// that fetch also uses.
package ic_pkg;

    localparam int unsigned LINES      = 64;
    localparam int unsigned LINE_WORDS = 8;
    localparam int unsigned DATA_BITS  = 32;
    localparam int unsigned WADDR_BITS = 30;
    localparam int unsigned WOFF_BITS  = $clog2(LINE_WORDS);
    localparam int unsigned OFF_BITS   = WOFF_BITS + 2;
    localparam int unsigned IDX_BITS   = $clog2(LINES);
    localparam int unsigned TAG_BITS   = 32 - IDX_BITS - OFF_BITS;
    localparam int unsigned LADDR_BITS = 32 - OFF_BITS;

    localparam logic [31:0] RESET_PC = 32'h1000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MREQ = 2'd1,
        FILL = 2'd2,
        RESP = 2'd3
    } ic_state_e;

    // Word address [31:2] split into tag / line index / word offset.
    typedef struct packed {
        logic [TAG_BITS-1:0]  tag;
        logic [IDX_BITS-1:0]  idx;
        logic [WOFF_BITS-1:0] off;
    } ic_waddr_t;

    function automatic logic [LADDR_BITS-1:0] line_addr(
        input logic [TAG_BITS-1:0] tag,
        input logic [IDX_BITS-1:0] idx
    );
        return {tag, idx};
    endfunction

endpackage

// File: rtl/icache_refill.sv
// Miss handling for icache_ctrl: refill FSM, beat counter, missed-word capture,
// error/cancel tracking and the memory read handshake.
// Ports:
//   miss / miss_addr / flush      - s2 miss indication, its address, fetch flush
//   idle_c                        - FSM is in IDLE (lookups allowed)
//   ic_mem_req / ic_mem_addr      - line read request to memory
//   mem_ic_*                      - memory handshake and refill beats
//   fill_*                        - array write controls for the top level
//   resp_valid_c / resp_error_c / resp_data - refill response toward fetch
module icache_refill
    import ic_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  miss,
    input  ic_waddr_t             miss_addr,
    input  logic                  flush,
    output logic                  idle_c,
    output logic                  ic_mem_req,
    output logic [LADDR_BITS-1:0] ic_mem_addr,
    input  logic                  mem_ic_ready,
    input  logic                  mem_ic_valid,
    input  logic                  mem_ic_error,
    input  logic [DATA_BITS-1:0]  mem_ic_data,
    output logic                  fill_we_c,
    output logic [IDX_BITS-1:0]   fill_idx,
    output logic [WOFF_BITS-1:0]  fill_word,
    output logic                  fill_install_c,
    output logic [TAG_BITS-1:0]   fill_tag,
    output logic                  resp_valid_c,
    output logic                  resp_error_c,
    output logic [DATA_BITS-1:0]  resp_data
);

    ic_state_e              state, state_nxt;
    logic [WOFF_BITS-1:0]   cnt, cnt_nxt;
    ic_waddr_t              tgt, tgt_nxt;
    logic [DATA_BITS-1:0]   resp_word, resp_word_nxt;
    logic                   err, err_nxt;
    logic                   cancel, cancel_nxt;

    assign ic_mem_addr = line_addr(tgt.tag, tgt.idx);
    assign fill_idx    = tgt.idx;
    assign fill_tag    = tgt.tag;
    assign fill_word   = cnt;
    assign resp_data   = resp_word;

    // State and refill bookkeeping registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            tgt       <= '0;
            resp_word <= '0;
            err       <= 1'b0;
            cancel    <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            tgt       <= tgt_nxt;
            resp_word <= resp_word_nxt;
            err       <= err_nxt;
            cancel    <= cancel_nxt;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        tgt_nxt        = tgt;
        resp_word_nxt  = resp_word;
        err_nxt        = err;
        cancel_nxt     = cancel;
        idle_c         = 1'b0;
        ic_mem_req     = 1'b0;
        fill_we_c      = 1'b0;
        fill_install_c = 1'b0;
        resp_valid_c   = 1'b0;
        resp_error_c   = 1'b0;

        case (state)
            IDLE: begin
                idle_c = 1'b1;
                if (miss) begin
                    tgt_nxt    = miss_addr;
                    cancel_nxt = flush;
                    state_nxt  = MREQ;
                end
            end
            MREQ: begin
                ic_mem_req = 1'b1;
                if (flush) cancel_nxt = 1'b1;
                if (mem_ic_ready) begin
                    cnt_nxt   = '0;
                    state_nxt = FILL;
                end
            end
            FILL: begin
                if (flush) cancel_nxt = 1'b1;
                if (mem_ic_valid) begin
                    fill_we_c = 1'b1;
                    cnt_nxt   = cnt + WOFF_BITS'(1);
                    err_nxt   = err | mem_ic_error;
                    if (cnt == tgt.off) resp_word_nxt = mem_ic_data;
                    // A faulted line is never marked valid.
                    if (cnt == WOFF_BITS'(LINE_WORDS - 1)) begin
                        fill_install_c = ~err_nxt;
                        state_nxt      = RESP;
                    end
                end
            end
            RESP: begin
                resp_valid_c = ~cancel;
                resp_error_c = err;
                err_nxt      = 1'b0;
                cancel_nxt   = 1'b0;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache in front of the fetch unit. One-cycle hit
// latency, one request per cycle, blocking refill of whole lines on a miss.
// Ports:
//   fetch_ic_req/addr/flush          - fetch lookup request and flush
//   icache_ready                     - request can be accepted this cycle
//   icache_valid/error/data          - in-order response to fetch
//   ic_mem_req/addr, mem_ic_*        - line refill port to memory
module icache_ctrl
    import ic_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_ic_req,
    input  logic [WADDR_BITS-1:0] fetch_ic_addr,
    input  logic                  fetch_ic_flush,
    output logic                  icache_ready,
    output logic                  icache_valid,
    output logic                  icache_error,
    output logic [DATA_BITS-1:0]  icache_data,
    output logic                  ic_mem_req,
    output logic [LADDR_BITS-1:0] ic_mem_addr,
    input  logic                  mem_ic_ready,
    input  logic                  mem_ic_valid,
    input  logic                  mem_ic_error,
    input  logic [DATA_BITS-1:0]  mem_ic_data
);

    localparam int unsigned DEPTH = LINES * LINE_WORDS;

    logic [DATA_BITS-1:0] data_mem [DEPTH];
    logic [TAG_BITS-1:0]  tag_mem  [LINES];
    logic [LINES-1:0]     line_valid;

    ic_waddr_t            req_addr;
    ic_waddr_t            s2_addr;
    logic                 s2_valid;
    logic                 s2_line_vld;
    logic [TAG_BITS-1:0]  s2_tag;
    logic [DATA_BITS-1:0] s2_word;
    logic                 run;

    logic                 accept_c;
    logic                 hit_c;
    logic                 s2_miss_c;
    logic                 idle_c;
    logic                 fill_we_c;
    logic                 fill_install_c;
    logic [IDX_BITS-1:0]  fill_idx;
    logic [WOFF_BITS-1:0] fill_word;
    logic [TAG_BITS-1:0]  fill_tag;
    logic                 resp_valid_c;
    logic                 resp_error_c;
    logic [DATA_BITS-1:0] resp_data;

    assign req_addr  = ic_waddr_t'(fetch_ic_addr);
    assign hit_c     = s2_valid & s2_line_vld & (s2_tag == s2_addr.tag);
    assign s2_miss_c = s2_valid & ~hit_c;

    // run holds ready low while reset is asserted and until the first edge after.
    assign icache_ready = run & idle_c & ~s2_miss_c;
    assign accept_c     = fetch_ic_req & icache_ready & ~fetch_ic_flush;

    // Response mux; only registered state feeds it, never fetch_ic_flush.
    assign icache_valid = hit_c | resp_valid_c;
    assign icache_error = resp_error_c;
    assign icache_data  = hit_c ? s2_word : resp_data;

    // s2 pipeline register and line valid bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run         <= 1'b0;
            s2_valid    <= 1'b0;
            s2_addr     <= ic_waddr_t'(RESET_PC[31:2]);
            s2_line_vld <= 1'b0;
            line_valid  <= '0;
        end else begin
            run      <= 1'b1;
            s2_valid <= accept_c;
            if (accept_c) begin
                s2_addr     <= req_addr;
                s2_line_vld <= line_valid[req_addr.idx];
            end
            // Line stays invalid from its first refill beat until a clean install.
            if (fill_we_c) line_valid[fill_idx] <= fill_install_c;
        end
    end

    // Tag/data arrays: synchronous read on accept, written by the refill.
    always_ff @(posedge clk) begin
        if (fill_we_c) data_mem[{fill_idx, fill_word}] <= mem_ic_data;
        if (fill_install_c) tag_mem[fill_idx] <= fill_tag;
        if (accept_c) begin
            s2_tag  <= tag_mem[req_addr.idx];
            s2_word <= data_mem[{req_addr.idx, req_addr.off}];
        end
    end

    icache_refill u_refill (
        .clk            (clk),
        .rst            (rst),
        .miss           (s2_miss_c),
        .miss_addr      (s2_addr),
        .flush          (fetch_ic_flush),
        .idle_c         (idle_c),
        .ic_mem_req     (ic_mem_req),
        .ic_mem_addr    (ic_mem_addr),
        .mem_ic_ready   (mem_ic_ready),
        .mem_ic_valid   (mem_ic_valid),
        .mem_ic_error   (mem_ic_error),
        .mem_ic_data    (mem_ic_data),
        .fill_we_c      (fill_we_c),
        .fill_idx       (fill_idx),
        .fill_word      (fill_word),
        .fill_install_c (fill_install_c),
        .fill_tag       (fill_tag),
        .resp_valid_c   (resp_valid_c),
        .resp_error_c   (resp_error_c),
        .resp_data      (resp_data)
    );

endmodule
